// File: rtl/alu_pipe_datapath.sv
// alu_pipe_datapath: register file, one-stage execute ALU and an iterative
// shift-add multiplier. An accepted instruction reads its operands at the
// accepting edge, with forwarding from a same-edge writeback. Single-cycle ops
// write back one edge later. MUL holds the issue port for DATA_W cycles.
module alu_pipe_datapath #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [7:0]        opcode,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_sel,
  input  logic              wb_en,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [3:0]        flags,
  output logic              err,
  input  logic              out_en,
  output logic [DATA_W-1:0] result_bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_NOT = 8'h05;
  localparam logic [7:0] OP_LSH = 8'h06;
  localparam logic [7:0] OP_RSH = 8'h07;
  localparam logic [7:0] OP_CMP = 8'h08;
  localparam logic [7:0] OP_MOV = 8'h09;
  localparam logic [7:0] OP_MUL = 8'h0A;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

  // Register file is flops: two operand reads plus the debug read are
  // combinational.
  logic [DATA_W-1:0] regs [NREGS];

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] mul_a_reg;
  logic [DATA_W-1:0] mul_b_reg;
  logic [DATA_W-1:0] mul_acc_reg;
  logic [ADDR_W-1:0] mul_rd_reg;
  logic              mul_wb_en_reg;

  logic              ex_valid_reg;
  logic [DATA_W-1:0] ex_a_reg;
  logic [DATA_W-1:0] ex_b_reg;
  logic [7:0]        ex_op_reg;
  logic [ADDR_W-1:0] ex_rd_reg;
  logic              ex_wb_en_reg;

  logic [DATA_W-1:0] result_reg;
  logic              result_valid_reg;
  logic [3:0]        flags_reg;
  logic              err_reg;

  logic              accept;
  logic              mul_done;
  logic [DATA_W-1:0] mul_sum;
  logic              ex_legal;
  logic              wb_fire;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] rt_val;

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] diff;
  logic              alu_c;
  logic              alu_f;

  // Ready while idle, or on MUL's final edge so the next op overlaps it.
  assign issue_ready = (state_reg == IDLE) || (cnt_reg == CNT_LAST);
  assign accept      = issue_valid && issue_ready;

  // MUL finishes on the edge where the last multiplier bit is folded in;
  // mul_sum is the accumulator including that bit.
  assign mul_done = (state_reg == MUL_BUSY) && (cnt_reg == CNT_LAST);
  assign mul_sum  = mul_acc_reg + (mul_b_reg[cnt_reg] ? (mul_a_reg << cnt_reg) : '0);

  // MUL never enters the execute stage, so only plain ops are legal there.
  assign ex_legal = (ex_op_reg < OP_MUL);

  // Writeback source: MUL completion and execute stage never coincide.
  always_comb begin
    wb_fire = 1'b0;
    wb_addr = ex_rd_reg;
    wb_data = alu_res;
    if (mul_done) begin
      wb_fire = mul_wb_en_reg;
      wb_addr = mul_rd_reg;
      wb_data = mul_sum;
    end else if (ex_valid_reg && ex_legal && ex_wb_en_reg && (ex_op_reg != OP_CMP)) begin
      wb_fire = 1'b1;
    end
  end

  // Operand read with forwarding of a writeback landing on the same edge.
  always_comb begin
    op_a   = regs[rs_addr];
    rt_val = regs[rt_addr];
    if (wb_fire && (wb_addr == rs_addr)) op_a = wb_data;
    if (wb_fire && (wb_addr == rt_addr)) rt_val = wb_data;
    op_b = imm_sel ? imm : rt_val;
  end

  // Execute-stage ALU; C and F default to their held values.
  always_comb begin
    sum_ext = {1'b0, ex_a_reg} + {1'b0, ex_b_reg};
    diff    = ex_a_reg - ex_b_reg;
    alu_res = '0;
    alu_c   = flags_reg[3];
    alu_f   = flags_reg[2];
    case (ex_op_reg)
      OP_ADD: begin
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        alu_f   = (ex_a_reg[DATA_W-1] == ex_b_reg[DATA_W-1]) &&
                  (sum_ext[DATA_W-1] != ex_a_reg[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff;
        alu_c   = (ex_a_reg < ex_b_reg);
        alu_f   = (ex_a_reg[DATA_W-1] != ex_b_reg[DATA_W-1]) &&
                  (diff[DATA_W-1] != ex_a_reg[DATA_W-1]);
      end
      OP_AND:  alu_res = ex_a_reg & ex_b_reg;
      OP_OR:   alu_res = ex_a_reg | ex_b_reg;
      OP_XOR:  alu_res = ex_a_reg ^ ex_b_reg;
      OP_NOT:  alu_res = ~ex_a_reg;
      OP_LSH:  alu_res = ex_a_reg << ex_b_reg[SH_W-1:0];
      OP_RSH:  alu_res = ex_a_reg >> ex_b_reg[SH_W-1:0];
      OP_MOV:  alu_res = ex_b_reg;
      default: alu_res = '0;
    endcase
  end

  // Register file write; reset clears every entry and wins over writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_fire) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Execute-stage capture of accepted single-cycle (and illegal) instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg <= 1'b0;
      ex_a_reg     <= '0;
      ex_b_reg     <= '0;
      ex_op_reg    <= '0;
      ex_rd_reg    <= '0;
      ex_wb_en_reg <= 1'b0;
    end else begin
      ex_valid_reg <= accept && (opcode != OP_MUL);
      if (accept) begin
        ex_a_reg     <= op_a;
        ex_b_reg     <= op_b;
        ex_op_reg    <= opcode;
        ex_rd_reg    <= rd_addr;
        ex_wb_en_reg <= wb_en;
      end
    end
  end

  // Multiplier FSM: one multiplier bit per edge, LSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      mul_acc_reg   <= '0;
      mul_rd_reg    <= '0;
      mul_wb_en_reg <= 1'b0;
    end else begin
      if (state_reg == MUL_BUSY) begin
        cnt_reg     <= cnt_reg + CNT_W'(1);
        mul_acc_reg <= mul_sum;
        if (cnt_reg == CNT_LAST) state_reg <= IDLE;
      end
      if (accept && (opcode == OP_MUL)) begin
        state_reg     <= MUL_BUSY;
        cnt_reg       <= '0;
        mul_a_reg     <= op_a;
        mul_b_reg     <= op_b;
        mul_acc_reg   <= '0;
        mul_rd_reg    <= rd_addr;
        mul_wb_en_reg <= wb_en;
      end
    end
  end

  // Registered result, flags and one-cycle valid / error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      flags_reg        <= '0;
      err_reg          <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      err_reg          <= 1'b0;
      if (mul_done) begin
        result_reg       <= mul_sum;
        result_valid_reg <= 1'b1;
        flags_reg[1]     <= (mul_sum == '0);
        flags_reg[0]     <= mul_sum[DATA_W-1];
      end else if (ex_valid_reg) begin
        if (ex_legal) begin
          result_reg       <= alu_res;
          result_valid_reg <= 1'b1;
          flags_reg        <= {alu_c, alu_f, (alu_res == '0), alu_res[DATA_W-1]};
        end else begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign flags        = flags_reg;
  assign err          = err_reg;
  assign result_bus   = out_en ? result_reg : 'z;
  assign dbg_data     = regs[dbg_addr];

endmodule
